fifo_ctrl: RTL and testbench
============================

FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the width of each stored word.
REQ-002 The block SHALL have parameter SIZE, default 1024, meaning the depth in words; it is a power of two and at least 2.
REQ-003 The block SHALL define localparam ADDRESS_WIDTH = $clog2(SIZE) and CW = ADDRESS_WIDTH+1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port resetn, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port push, input, 1 bit: write request.
REQ-007 The block SHALL have port push_data, input, DATA_WIDTH bits: the word to write.
REQ-008 The block SHALL have port pop, input, 1 bit: read request.
REQ-009 The block SHALL have port pop_data, output, DATA_WIDTH bits: the read word, valid when pop_valid is high.
REQ-010 The block SHALL have port pop_valid, output, 1 bit: pop_data is valid this cycle.
REQ-011 The block SHALL have ports full and empty, output, 1 bit each: the occupancy flags.
REQ-012 The block SHALL have port count, output, CW bits: the number of stored words.
REQ-013 The block SHALL have ports overflow and underflow, output, 1 bit each: sticky error flags.
REQ-014 The block SHALL have output RAM write-side ports ram_w_enable (1 bit), ram_w_address (ADDRESS_WIDTH bits) and ram_w_data (DATA_WIDTH bits).
REQ-015 The block SHALL have output RAM read-side ports ram_r_enable (1 bit) and ram_r_address (ADDRESS_WIDTH bits).
REQ-016 The block SHALL have input port ram_r_data, DATA_WIDTH bits, carrying the registered RAM read output (1-cycle latency).

Function
REQ-017 push_ok SHALL equal push & ~full, and pop_ok SHALL equal pop & ~empty; both are combinational from registered flags.
REQ-018 ram_w_enable SHALL equal push_ok, ram_w_address SHALL equal wr_ptr, and ram_w_data SHALL equal push_data, all combinational.
REQ-019 ram_r_enable SHALL equal pop_ok and ram_r_address SHALL equal rd_ptr, both combinational.
REQ-020 wr_ptr and rd_ptr SHALL be ADDRESS_WIDTH-bit registers that increment by 1 on push_ok and pop_ok respectively, wrapping from SIZE-1 to 0.
REQ-021 count SHALL increment on push_ok only, decrement on pop_ok only, and hold when both or neither occur.
REQ-022 full SHALL be (count==SIZE) and empty SHALL be (count==0), both derived from the registered count.
REQ-023 pop_valid SHALL be a register loaded with pop_ok, so it asserts exactly 1 cycle after an accepted pop.
REQ-024 pop_data SHALL equal ram_r_data, passed through.
REQ-025 When full, a simultaneous push and pop SHALL accept the pop, reject the push, set overflow, and leave count at SIZE-1.
REQ-026 When empty, a simultaneous push and pop SHALL accept the push, reject the pop, and set underflow; there is no fall-through.
REQ-027 When not full and not empty, a simultaneous push and pop SHALL both be accepted, with count unchanged and read-before-write on distinct addresses.
REQ-028 overflow SHALL set on push & full, and underflow SHALL set on pop & empty; both are sticky until reset.
REQ-029 Data SHALL be returned in strict FIFO order across pointer wrap-around.

Reset
REQ-030 While resetn is low at a clk edge, wr_ptr, rd_ptr and count SHALL be set to 0, pop_valid, overflow and underflow to 0, empty to 1 and full to 0.
REQ-031 While resetn is low, ram_w_enable and ram_r_enable SHALL be forced to 0.
REQ-032 RAM contents SHALL NOT be cleared by reset.
REQ-033 A reset during operation SHALL discard all stored words and suppress any pending pop_valid on the following cycle.

Verification (SIZE=4, DATA_WIDTH=8, behavioural 1-cycle RAM model)
REQ-034 The bench SHALL check reset: resetn=0 for 2 cycles -> count=0, empty=1, full=0, pop_valid=0, no RAM enables.
REQ-035 The bench SHALL check fill and drain: push 0x11,0x22,0x33,0x44 -> full=1, count=4; then pop x4 -> pop_data 0x11,0x22,0x33,0x44, each with pop_valid 1 cycle after its pop; then empty=1.
REQ-036 The bench SHALL check overflow: when full, push 0x55 -> ram_w_enable=0, overflow=1, count stays 4, and a later drain returns no 0x55.
REQ-037 The bench SHALL check underflow and the empty push+pop case: when empty, push 0xA0 with pop -> underflow=1, pop_valid=0 next cycle, count=1.
REQ-038 The bench SHALL check wrap-around: perform 6 pushes interleaved with pops (count never above 3) -> all words are returned in order, and the pointers wrap 3->0.
REQ-039 The bench SHALL check mid-operation reset: with count=2, apply resetn=0 on the cycle after a pop -> pop_valid=0, count=0, and flags are cleared.

Source files
------------

// File: rtl/fifo_ctrl.sv
// FIFO controller driving an external RAM with a registered (1-cycle) read port.
// Tracks occupancy, issues RAM read/write strobes and raises sticky error flags.
//
// Ports:
//   clk           : single clock, all state changes on its rising edge
//   resetn        : synchronous active-low reset
//   push          : write request, push_data is the word to store
//   pop           : read request
//   pop_data      : read word, valid while pop_valid is high
//   pop_valid     : asserted exactly one cycle after an accepted pop
//   full / empty  : occupancy flags derived from the registered count
//   count         : number of stored words (0 .. SIZE)
//   overflow      : sticky, set by a push while full
//   underflow     : sticky, set by a pop while empty
//   ram_w_*       : RAM write port (enable, address, data)
//   ram_r_*       : RAM read port (enable, address); ram_r_data returns a cycle later

module fifo_ctrl #(
    parameter  int DATA_WIDTH    = 8,
    parameter  int SIZE          = 1024,
    localparam int ADDRESS_WIDTH = $clog2(SIZE),
    localparam int CW            = ADDRESS_WIDTH + 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [DATA_WIDTH-1:0]    push_data,
    input  logic                     pop,
    output logic [DATA_WIDTH-1:0]    pop_data,
    output logic                     pop_valid,
    output logic                     full,
    output logic                     empty,
    output logic [CW-1:0]            count,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     ram_w_enable,
    output logic [ADDRESS_WIDTH-1:0] ram_w_address,
    output logic [DATA_WIDTH-1:0]    ram_w_data,
    output logic                     ram_r_enable,
    output logic [ADDRESS_WIDTH-1:0] ram_r_address,
    input  logic [DATA_WIDTH-1:0]    ram_r_data
);

    logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
    logic [ADDRESS_WIDTH-1:0] r_rd_ptr;
    logic [CW-1:0]            r_count;
    logic                     r_pop_valid;
    logic                     r_overflow;
    logic                     r_underflow;

    logic                     w_full;
    logic                     w_empty;
    logic                     w_push_ok;
    logic                     w_pop_ok;
    logic [CW-1:0]            w_count_nxt;

    // Flags come straight from the registered count, so the accept
    // decisions never depend on same-cycle request inputs.
    assign w_full    = (r_count == CW'(SIZE));
    assign w_empty   = (r_count == '0);
    assign w_push_ok = push & ~w_full;
    assign w_pop_ok  = pop & ~w_empty;

    // Strobes are gated by resetn so a reset cycle never touches the RAM.
    assign ram_w_enable  = w_push_ok & resetn;
    assign ram_w_address = r_wr_ptr;
    assign ram_w_data    = push_data;
    assign ram_r_enable  = w_pop_ok & resetn;
    assign ram_r_address = r_rd_ptr;

    assign pop_data  = ram_r_data;
    assign pop_valid = r_pop_valid;
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // SIZE is a power of two, so the natural ADDRESS_WIDTH overflow
    // is the SIZE-1 -> 0 wrap.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + ADDRESS_WIDTH'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + ADDRESS_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    // Tracks the RAM read latency; a reset drops any read in flight.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pop_valid <= 1'b0;
        end else begin
            r_pop_valid <= w_pop_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (push & w_full) begin
                r_overflow <= 1'b1;
            end
            if (pop & w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl (SIZE=4, DATA_WIDTH=8) with a 1-cycle RAM model.
// Directed scenarios plus randomized traffic checked against a queue-based model.

module tb_fifo_ctrl;

    localparam int DW = 8;
    localparam int SZ = 4;
    localparam int AW = 2;
    localparam int CW = 3;

    logic          clk;
    logic          resetn;
    logic          push;
    logic [DW-1:0] push_data;
    logic          pop;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;
    logic          ram_w_enable;
    logic [AW-1:0] ram_w_address;
    logic [DW-1:0] ram_w_data;
    logic          ram_r_enable;
    logic [AW-1:0] ram_r_address;
    logic [DW-1:0] ram_r_data;

    fifo_ctrl #(
        .DATA_WIDTH (DW),
        .SIZE       (SZ)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .push          (push),
        .push_data     (push_data),
        .pop           (pop),
        .pop_data      (pop_data),
        .pop_valid     (pop_valid),
        .full          (full),
        .empty         (empty),
        .count         (count),
        .overflow      (overflow),
        .underflow     (underflow),
        .ram_w_enable  (ram_w_enable),
        .ram_w_address (ram_w_address),
        .ram_w_data    (ram_w_data),
        .ram_r_enable  (ram_r_enable),
        .ram_r_address (ram_r_address),
        .ram_r_data    (ram_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [SZ];

    always @(posedge clk) begin
        if (ram_w_enable) mem[ram_w_address] <= ram_w_data;
        if (ram_r_enable) ram_r_data <= mem[ram_r_address];
    end

    // Reference model: a queue of stored words plus sticky flags.
    logic [DW-1:0] mq [$];
    bit            m_ovf;
    bit            m_udf;
    bit            m_pv;
    logic [DW-1:0] m_pd;
    int            m_wr;
    int            m_rd;

    int n_vec;
    int n_err;

    logic [DW-1:0] fill [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    task automatic tick();
        bit f;
        bit e;
        f = (mq.size() == SZ);
        e = (mq.size() == 0);
        if (!resetn) begin
            mq.delete();
            m_ovf = 0;
            m_udf = 0;
            m_pv  = 0;
            m_wr  = 0;
            m_rd  = 0;
        end else begin
            if (push && f) m_ovf = 1;
            if (pop && e) m_udf = 1;
            m_pv = pop && !e;
            if (pop && !e) begin
                m_pd = mq.pop_front();
                m_rd++;
            end
            if (push && !f) begin
                mq.push_back(push_data);
                m_wr++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        push   = 1'b0;
        pop    = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
        tick();
        push = 1'b1;
        pop  = 1'b1;
        push_data = 8'hEE;
        #1;
        n_vec++;
        if (ram_w_enable !== 1'b0 || ram_r_enable !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ram_en: w=%b r=%b want 0 0",
                     ram_w_enable, ram_r_enable);
        end
        tick();
        push = 1'b0;
        pop  = 1'b0;
        n_vec++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
            n_err++;
            $display("FAIL reset_occ: count=%0d empty=%b full=%b want 0 1 0",
                     count, empty, full);
        end
        n_vec++;
        if (pop_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: pv=%b ovf=%b udf=%b want 0 0 0",
                     pop_valid, overflow, underflow);
        end
        resetn = 1'b1;
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push = 1'b1;
            push_data = fill[i];
            #1;
            n_vec++;
            if (ram_w_enable !== 1'b1 || ram_w_address !== AW'(i)
                || ram_w_data !== fill[i]) begin
                n_err++;
                $display("FAIL fill_wr%0d: en=%b addr=%0d data=%h want 1 %0d %h",
                         i, ram_w_enable, ram_w_address, ram_w_data, i, fill[i]);
            end
            tick();
            push = 1'b0;
        end
        n_vec++;
        if (full !== 1'b1 || count !== 3'd4 || empty !== 1'b0) begin
            n_err++;
            $display("FAIL fill_full: full=%b count=%0d empty=%b want 1 4 0",
                     full, count, empty);
        end
        for (int i = 0; i < 4; i++) begin
            pop = 1'b1;
            #1;
            n_vec++;
            if (ram_r_enable !== 1'b1 || ram_r_address !== AW'(i)) begin
                n_err++;
                $display("FAIL drain_rd%0d: en=%b addr=%0d want 1 %0d",
                         i, ram_r_enable, ram_r_address, i);
            end
            tick();
            pop = 1'b0;
            n_vec++;
            if (pop_valid !== 1'b1 || pop_data !== fill[i]) begin
                n_err++;
                $display("FAIL drain_data%0d: pv=%b data=%h want 1 %h",
                         i, pop_valid, pop_data, fill[i]);
            end
            tick();
            n_vec++;
            if (pop_valid !== 1'b0) begin
                n_err++;
                $display("FAIL drain_pv_drop%0d: pv=%b want 0", i, pop_valid);
            end
        end
        n_vec++;
        if (empty !== 1'b1 || count !== 3'd0) begin
            n_err++;
            $display("FAIL drain_empty: empty=%b count=%0d want 1 0", empty, count);
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] exp_d [3] = '{8'h22, 8'h33, 8'h44};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push = 1'b1;
            push_data = fill[i];
            tick();
        end
        push_data = 8'h55;
        #1;
        n_vec++;
        if (ram_w_enable !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_wen: en=%b want 0", ram_w_enable);
        end
        tick();
        push = 1'b0;
        n_vec++;
        if (overflow !== 1'b1 || count !== 3'd4 || underflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_flag: ovf=%b count=%0d udf=%b want 1 4 0",
                     overflow, count, underflow);
        end
        push = 1'b1;
        pop  = 1'b1;
        push_data = 8'h66;
        #1;
        n_vec++;
        if (ram_w_enable !== 1'b0 || ram_r_enable !== 1'b1) begin
            n_err++;
            $display("FAIL full_pp_en: w=%b r=%b want 0 1", ram_w_enable, ram_r_enable);
        end
        tick();
        push = 1'b0;
        n_vec++;
        if (count !== 3'd3 || pop_valid !== 1'b1 || pop_data !== 8'h11) begin
            n_err++;
            $display("FAIL full_pp: count=%0d pv=%b data=%h want 3 1 11",
                     count, pop_valid, pop_data);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (pop_valid !== 1'b1 || pop_data !== exp_d[i]) begin
                n_err++;
                $display("FAIL ovf_drain%0d: pv=%b data=%h want 1 %h",
                         i, pop_valid, pop_data, exp_d[i]);
            end
        end
        pop = 1'b0;
        tick();
        n_vec++;
        if (empty !== 1'b1 || overflow !== 1'b1 || pop_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_sticky: empty=%b ovf=%b pv=%b want 1 1 0",
                     empty, overflow, pop_valid);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        push = 1'b1;
        pop  = 1'b1;
        push_data = 8'hA0;
        #1;
        n_vec++;
        if (ram_w_enable !== 1'b1 || ram_r_enable !== 1'b0) begin
            n_err++;
            $display("FAIL udf_en: w=%b r=%b want 1 0", ram_w_enable, ram_r_enable);
        end
        tick();
        push = 1'b0;
        pop  = 1'b0;
        n_vec++;
        if (underflow !== 1'b1 || pop_valid !== 1'b0 || count !== 3'd1) begin
            n_err++;
            $display("FAIL udf_flag: udf=%b pv=%b count=%0d want 1 0 1",
                     underflow, pop_valid, count);
        end
        pop = 1'b1;
        tick();
        pop = 1'b0;
        n_vec++;
        if (pop_valid !== 1'b1 || pop_data !== 8'hA0 || empty !== 1'b1) begin
            n_err++;
            $display("FAIL udf_read: pv=%b data=%h empty=%b want 1 a0 1",
                     pop_valid, pop_data, empty);
        end
    endtask

    task automatic test_wrap();
        // 1 = push, 0 = pop; occupancy peaks at 3
        bit ops [12] = '{1, 1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            push = ops[i];
            pop  = !ops[i];
            push_data = 8'($urandom);
            #1;
            n_vec++;
            if (ops[i] && ram_w_address !== AW'(m_wr % SZ)) begin
                n_err++;
                $display("FAIL wrap_waddr%0d: got %0d want %0d",
                         i, ram_w_address, m_wr % SZ);
            end
            if (!ops[i] && ram_r_address !== AW'(m_rd % SZ)) begin
                n_err++;
                $display("FAIL wrap_raddr%0d: got %0d want %0d",
                         i, ram_r_address, m_rd % SZ);
            end
            tick();
            n_vec++;
            if (count !== CW'(mq.size()) || pop_valid !== m_pv
                || (m_pv && pop_data !== m_pd)) begin
                n_err++;
                $display("FAIL wrap_step%0d: count=%0d pv=%b data=%h want %0d %b %h",
                         i, count, pop_valid, pop_data, mq.size(), m_pv, m_pd);
            end
        end
        push = 1'b0;
        pop  = 1'b0;
        n_vec++;
        if (m_wr != 6 || ram_w_address !== 2'd2 || ram_r_address !== 2'd2) begin
            n_err++;
            $display("FAIL wrap_ptrs: wa=%0d ra=%0d want 2 2",
                     ram_w_address, ram_r_address);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        pop = 1'b1;
        tick();
        pop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push = 1'b1;
            push_data = 8'hC0 + 8'(i);
            tick();
        end
        push = 1'b0;
        pop  = 1'b1;
        tick();
        n_vec++;
        if (count !== 3'd2 || pop_valid !== 1'b1 || underflow !== 1'b1) begin
            n_err++;
            $display("FAIL mrst_pre: count=%0d pv=%b udf=%b want 2 1 1",
                     count, pop_valid, underflow);
        end
        resetn = 1'b0;
        #1;
        n_vec++;
        if (ram_r_enable !== 1'b0) begin
            n_err++;
            $display("FAIL mrst_ren: en=%b want 0", ram_r_enable);
        end
        tick();
        pop = 1'b0;
        resetn = 1'b1;
        n_vec++;
        if (pop_valid !== 1'b0 || count !== 3'd0 || empty !== 1'b1
            || full !== 1'b0 || underflow !== 1'b0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL mrst_post: pv=%b count=%0d e=%b f=%b udf=%b ovf=%b",
                     pop_valid, count, empty, full, underflow, overflow);
        end
        push = 1'b1;
        push_data = 8'h77;
        tick();
        push = 1'b0;
        pop  = 1'b1;
        tick();
        pop = 1'b0;
        n_vec++;
        if (pop_valid !== 1'b1 || pop_data !== 8'h77 || empty !== 1'b1) begin
            n_err++;
            $display("FAIL mrst_fresh: pv=%b data=%h empty=%b want 1 77 1",
                     pop_valid, pop_data, empty);
        end
    endtask

    task automatic test_random();
        bit ew;
        bit er;
        int bias;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bias = ((i / 50) % 2 == 0) ? 70 : 30;
            resetn = ($urandom_range(59, 0) != 0);
            push = ($urandom_range(99, 0) < bias);
            pop  = ($urandom_range(99, 0) < (100 - bias));
            push_data = 8'($urandom);
            #1;
            ew = resetn && push && (mq.size() < SZ);
            er = resetn && pop && (mq.size() > 0);
            n_vec++;
            if (ram_w_enable !== ew || ram_r_enable !== er
                || (ew && (ram_w_address !== AW'(m_wr % SZ)
                           || ram_w_data !== push_data))
                || (er && ram_r_address !== AW'(m_rd % SZ))) begin
                n_err++;
                $display("FAIL rnd_ram%0d: we=%b wa=%0d re=%b ra=%0d want %b %0d %b %0d",
                         i, ram_w_enable, ram_w_address, ram_r_enable,
                         ram_r_address, ew, m_wr % SZ, er, m_rd % SZ);
            end
            tick();
            n_vec++;
            if (count !== CW'(mq.size()) || full !== (mq.size() == SZ)
                || empty !== (mq.size() == 0)) begin
                n_err++;
                $display("FAIL rnd_occ%0d: count=%0d f=%b e=%b want %0d",
                         i, count, full, empty, mq.size());
            end
            n_vec++;
            if (pop_valid !== m_pv || (m_pv && pop_data !== m_pd)
                || overflow !== m_ovf || underflow !== m_udf) begin
                n_err++;
                $display("FAIL rnd_out%0d: pv=%b d=%h ovf=%b udf=%b want %b %h %b %b",
                         i, pop_valid, pop_data, overflow, underflow,
                         m_pv, m_pd, m_ovf, m_udf);
            end
        end
        resetn = 1'b1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        resetn = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
        push_data = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
